adc_sample_sequencer: RTL and testbench

Scan sequencer between the ADC APB register block and the ADC core. A single trigger starts a scan over a channel mask. For each enabled channel the block drives the analog-mux select, waits a programmable settle time, pulses the ADC conversion start and waits for done (with timeout). Each channel-tagged result is pushed into a small FIFO that the APB side pops.

---
 rtl/adc_seq_pkg.sv | 19 +
 rtl/adc_result_fifo.sv | 66 ++++++
 rtl/adc_sample_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the ADC scan sequencer and its result FIFO.
package adc_seq_pkg;

    localparam int ADC_NUM_CH         = 8;
    localparam int ADC_CH_W           = 3;
    localparam int ADC_DATA_W         = 12;
    localparam int ADC_RES_W          = ADC_CH_W + ADC_DATA_W;
    localparam int ADC_SETTLE_W       = 8;
    localparam int ADC_FIFO_DEPTH     = 4;
    localparam int ADC_TIMEOUT_CYCLES = 1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONVERT,
        ST_STORE
    } seq_state_e;

endpackage

// File: rtl/adc_result_fifo.sv
// First-word fall-through result FIFO; a pop frees a slot for a push in the same cycle.
module adc_result_fifo
    import adc_seq_pkg::*;
#(
    parameter int WIDTH = ADC_RES_W,
    parameter int DEPTH = ADC_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Storage is not reset, so the head reads as zero whenever nothing is queued.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/adc_sample_sequencer.sv
// Walks the enabled channel mask: mux select, settle, convert with timeout, store result.
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NUM_CH         = ADC_NUM_CH,
    parameter int CH_W           = ADC_CH_W,
    parameter int DATA_W         = ADC_DATA_W,
    parameter int SETTLE_W       = ADC_SETTLE_W,
    parameter int FIFO_DEPTH     = ADC_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = ADC_TIMEOUT_CYCLES
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          cfg_start,
    input  logic [NUM_CH-1:0]             cfg_ch_mask,
    input  logic [SETTLE_W-1:0]           cfg_settle,
    input  logic                          cfg_continuous,
    input  logic                          cfg_abort,
    input  logic                          err_clr,
    output logic [CH_W-1:0]               amux_sel,
    output logic                          adc_start,
    input  logic                          adc_done,
    input  logic [DATA_W-1:0]             adc_data,
    output logic                          res_valid,
    output logic [CH_W+DATA_W-1:0]        res_data,
    input  logic                          res_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          overflow
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW1   = CH_W + 1;
    localparam int RES_W = CH_W + DATA_W;

    // Returns {found, index} of the lowest set bit of m at or above 'from'.
    function automatic logic [CW1-1:0] find_from(input logic [NUM_CH-1:0] m,
                                                 input logic [CW1-1:0]    from);
        logic [CW1-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (CW1'(i) >= from)) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    seq_state_e          state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                cont_q, cont_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]     wcnt_q, wcnt_d;
    logic [CH_W-1:0]     amux_q, amux_d;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                have_q, have_d;
    logic                tmo_q, tmo_d;
    logic                ovf_q, ovf_d;

    logic                push, pop, tmo_set, ovf_set;
    logic                fifo_full, fifo_empty;
    logic [CW1-1:0]      first_hit, next_hit, wrap_hit;

    assign first_hit = find_from(cfg_ch_mask, '0);
    assign next_hit  = find_from(mask_q, {1'b0, amux_q} + CW1'(1));
    assign wrap_hit  = find_from(mask_q, '0);
    assign pop       = !fifo_empty && res_ready;

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        settle_d = settle_q;
        cont_d   = cont_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        amux_d   = amux_q;
        start_d  = 1'b0;
        data_d   = data_q;
        have_d   = have_q;
        push     = 1'b0;
        tmo_set  = 1'b0;
        ovf_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && first_hit[CH_W]) begin
                    mask_d   = cfg_ch_mask;
                    settle_d = cfg_settle;
                    cont_d   = cfg_continuous;
                    amux_d   = first_hit[CH_W-1:0];
                    cnt_d    = cfg_settle;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CONVERT;
                    start_d = 1'b1;
                    wcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CONVERT: begin
                // A done coincident with our own start pulse belongs to nothing we issued.
                if (adc_done && !start_q) begin
                    data_d  = adc_data;
                    have_d  = 1'b1;
                    state_d = ST_STORE;
                end else if (wcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set = 1'b1;
                    have_d  = 1'b0;
                    state_d = ST_STORE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_STORE: begin
                push    = have_q;
                ovf_set = have_q && fifo_full && !pop;
                cnt_d   = settle_q;
                if (next_hit[CH_W]) begin
                    amux_d  = next_hit[CH_W-1:0];
                    state_d = ST_SETTLE;
                end else if (cont_q && wrap_hit[CH_W]) begin
                    amux_d  = wrap_hit[CH_W-1:0];
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops whatever the scan was about to do this edge.
        if (cfg_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            amux_d  = amux_q;
            start_d = 1'b0;
            push    = 1'b0;
            tmo_set = 1'b0;
            ovf_set = 1'b0;
        end

        tmo_d = (tmo_q && !err_clr) || tmo_set;
        ovf_d = (ovf_q && !err_clr) || ovf_set;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            settle_q <= '0;
            cont_q   <= 1'b0;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            amux_q   <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            have_q   <= 1'b0;
            tmo_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            settle_q <= settle_d;
            cont_q   <= cont_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            amux_q   <= amux_d;
            start_q  <= start_d;
            data_q   <= data_d;
            have_q   <= have_d;
            tmo_q    <= tmo_d;
            ovf_q    <= ovf_d;
        end
    end

    adc_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_n_i (PRESETn),
        .push_i  (push),
        .din_i   ({amux_q, data_q}),
        .pop_i   (res_ready),
        .dout_o  (res_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign amux_sel    = amux_q;
    assign adc_start   = start_q;
    assign res_valid   = !fifo_empty;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = tmo_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomised bench for adc_sample_sequencer: scan-order and FIFO scoreboard plus directed timing checks.
module tb_adc_sample_sequencer;

    logic        PCLK;
    logic        PRESETn;
    logic        cfg_start;
    logic [7:0]  cfg_ch_mask;
    logic [7:0]  cfg_settle;
    logic        cfg_continuous;
    logic        cfg_abort;
    logic        err_clr;
    logic [2:0]  amux_sel;
    logic        adc_start;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        res_valid;
    logic [14:0] res_data;
    logic        res_ready;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        timeout_err;
    logic        overflow;

    adc_sample_sequencer dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .cfg_start      (cfg_start),
        .cfg_ch_mask    (cfg_ch_mask),
        .cfg_settle     (cfg_settle),
        .cfg_continuous (cfg_continuous),
        .cfg_abort      (cfg_abort),
        .err_clr        (err_clr),
        .amux_sel       (amux_sel),
        .adc_start      (adc_start),
        .adc_done       (adc_done),
        .adc_data       (adc_data),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .fifo_level     (fifo_level),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .overflow       (overflow)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int nchk = 0;
    int nerr = 0;

    // reference model state
    logic [14:0] mq[$];
    int          chq[$];
    logic [14:0] pend_word;
    logic [2:0]  cur_ch;
    bit          push_now, push_next, exp_ovf, prev_start;
    int          cd = -1;
    int          gcyc, last_done = -1, cur_s;
    int          n_done, n_start;
    // ADC responder knobs
    bit          resp_en, fix_en, rnd_ready;
    int          lat_lo = 1, lat_hi = 1;
    logic [11:0] fix_val;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Applies the coming edge to the model, advances one cycle, plays the ADC, checks the FIFO view.
    task automatic tick();
        bit pop, full;
        if (!PRESETn) begin
            mq.delete();
            exp_ovf   = 0;
            push_now  = 0;
            push_next = 0;
            cd        = -1;
        end else begin
            if (cfg_abort) begin
                push_now  = 0;
                push_next = 0;
                cd        = -1;
            end
            if (err_clr) exp_ovf = 0;
            full = (mq.size() == 4);
            pop  = (mq.size() != 0) && res_ready;
            if (pop) void'(mq.pop_front());
            if (push_now) begin
                if (full && !pop) exp_ovf = 1;
                else mq.push_back(pend_word);
            end
            push_now  = push_next;
            push_next = 0;
        end

        @(posedge PCLK);
        #1;
        gcyc++;

        adc_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                adc_data  = fix_en ? fix_val : 12'($urandom);
                adc_done  = 1'b1;
                pend_word = {cur_ch, adc_data};
                push_next = 1;
                n_done++;
                last_done = gcyc;
            end
        end
        if (adc_start) begin
            int exp_ch;
            n_start++;
            chk("start_pulse", prev_start, 0);
            exp_ch = (chq.size() != 0) ? chq.pop_front() : -1;
            chk("amux_at_start", amux_sel, exp_ch);
            cur_ch = 3'(exp_ch);
            if (last_done >= 0) chk("start_gap", (gcyc - last_done) >= (cur_s + 3), 1);
            if (resp_en) cd = $urandom_range(lat_hi, lat_lo);
        end
        prev_start = adc_start;

        chk("res_valid", res_valid, mq.size() != 0);
        chk("fifo_level", fifo_level, mq.size());
        chk("res_data", res_data, (mq.size() != 0) ? mq[0] : 15'd0);
        chk("overflow", overflow, exp_ovf);
        if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        PRESETn = 0; cfg_start = 0; cfg_ch_mask = 0; cfg_settle = 0;
        cfg_continuous = 0; cfg_abort = 0; err_clr = 0; res_ready = 0;
        adc_done = 0; adc_data = 0;
        repeat (2) tick();
        chk("rst_amux", amux_sel, 0);
        chk("rst_start", adc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);
        PRESETn = 1;
        tick();
    endtask

    // Drives the trigger in the current cycle; returns in cycle 1 of the scan.
    task automatic start_scan(logic [7:0] mask, int s, bit cont);
        chq.delete();
        for (int r = 0; r < (cont ? 8 : 1); r++)
            for (int i = 0; i < 8; i++)
                if (mask[i]) chq.push_back(i);
        cur_s = s; last_done = -1;
        cfg_ch_mask = mask; cfg_settle = 8'(s); cfg_continuous = cont; cfg_start = 1;
        tick();
        cfg_start = 0;
        cfg_ch_mask = 8'($urandom); cfg_settle = 8'($urandom); cfg_continuous = 1'($urandom);
    endtask

    task automatic wait_idle(int max);
        int g = 0;
        while (busy && g < max) begin tick(); g++; end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_done(int k, int max);
        int n0 = n_done;
        int g = 0;
        while ((n_done - n0) < k && g < max) begin tick(); g++; end
        chk("wait_done", n_done - n0, k);
    endtask

    task automatic wait_start(int max);
        int g = 0;
        while (!adc_start && g < max) begin tick(); g++; end
        chk("wait_start", adc_start, 1);
    endtask

    task automatic pulse_clr();
        err_clr = 1; tick(); err_clr = 0;
    endtask

    initial begin
        int lvl, ns0;
        do_reset();

        // single channel, exact timing
        resp_en = 1; fix_en = 1; fix_val = 12'hABC; lat_lo = 5; lat_hi = 5;
        start_scan(8'h04, 3, 0);
        for (int c = 1; c <= 12; c++) begin
            chk("t1_start", adc_start, c == 5);
            chk("t1_busy", busy, c <= 11);
            if (c <= 11) chk("t1_amux", amux_sel, 2);
            if (c == 12) chk("t1_data", res_data, {3'd2, 12'hABC});
            tick();
        end
        res_ready = 1; tick(); res_ready = 0;

        // channel order 0 then 7
        fix_en = 0; lat_lo = 1; lat_hi = 4;
        start_scan(8'h81, 0, 0);
        wait_idle(200);
        chk("t2_level", fifo_level, 2);
        chk("t2_head", res_data[14:12], 0);
        res_ready = 1; tick();
        chk("t2_second", res_data[14:12], 7);
        tick(); res_ready = 0;
        chk("t2_empty", fifo_level, 0);
        chk("t2_chq", chq.size(), 0);

        // timeout: ADC never answers
        resp_en = 0;
        start_scan(8'h01, $urandom_range(0, 3), 0);
        wait_start(20);
        repeat (1022) tick();
        chk("t3_tmo_early", timeout_err, 0);
        chk("t3_busy_wait", busy, 1);
        tick();
        chk("t3_tmo_set", timeout_err, 1);
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_no_push", fifo_level, 0);
        pulse_clr();
        chk("t3_tmo_clr", timeout_err, 0);

        // overflow with FIFO held full
        resp_en = 1; lat_lo = 1; lat_hi = 3;
        start_scan(8'h01, $urandom_range(0, 2), 1);
        wait_done(5, 400);
        tick(); tick();
        chk("t4_ovf", overflow, 1);
        chk("t4_level", fifo_level, 4);
        cfg_abort = 1; tick(); cfg_abort = 0;
        pulse_clr();
        // full push coinciding with a pop
        start_scan(8'h01, $urandom_range(0, 2), 1);
        wait_done(1, 100);
        tick();
        res_ready = 1; tick(); res_ready = 0;
        chk("t4_no_ovf", overflow, 0);
        chk("t4_level_full", fifo_level, 4);
        cfg_abort = 1; tick(); cfg_abort = 0;
        res_ready = 1; repeat (5) tick(); res_ready = 0;

        // continuous wrap 1,2,1,2 then abort in SETTLE
        rnd_ready = 1;
        start_scan(8'h06, $urandom_range(1, 4), 1);
        wait_done(4, 400);
        tick(); tick();
        rnd_ready = 0; res_ready = 0;
        cfg_abort = 1; tick(); cfg_abort = 0;
        chk("t5_abort_idle", busy, 0);
        chk("t5_abort_nostart", adc_start, 0);
        chk("t5_chq", chq.size(), 12);
        lvl = fifo_level; ns0 = n_start;
        repeat (10) tick();
        chk("t5_quiet", n_start, ns0);
        chk("t5_fifo_kept", fifo_level, lvl);
        res_ready = 1; repeat (5) tick(); res_ready = 0;

        // randomised single scans
        lat_lo = 1; lat_hi = 6;
        for (int k = 0; k < 6; k++) begin
            rnd_ready = 1;
            start_scan(8'($urandom_range(1, 255)), $urandom_range(0, 4), 0);
            wait_idle(3000);
            chk("rnd_all_ch", chq.size(), 0);
            rnd_ready = 0; res_ready = 0;
            pulse_clr();
        end
        res_ready = 1; repeat (5) tick(); res_ready = 0;

        // ignored start while busy, reset mid-conversion, zero-mask start
        lat_lo = 2; lat_hi = 2;
        start_scan(8'h01, 0, 0);
        wait_idle(50);
        resp_en = 0;
        start_scan(8'h02, 1, 0);
        wait_start(20);
        tick();
        cfg_ch_mask = 8'hFF; cfg_start = 1; tick(); cfg_start = 0;
        chk("t6_busy_ign", busy, 1);
        chk("t6_amux_ign", amux_sel, 1);
        PRESETn = 0; tick();
        chk("t6_rst_amux", amux_sel, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_start", adc_start, 0);
        chk("t6_rst_tmo", timeout_err, 0);
        PRESETn = 1; tick();
        cfg_ch_mask = 8'h00; cfg_start = 1; tick(); cfg_start = 0;
        chk("t6_zero_mask", busy, 0);
        tick();
        chk("t6_zero_nostart", adc_start, 0);
        chk("t6_zero_amux", amux_sel, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
